master_spi: RTL and testbench

//  FPGA-side SPI master speaking the AVR-slave register protocol: register number shifted with CS_n HIGH, payload with CS_n LOW, commit on CS_n rising edge.

---
 rtl/master_spi_pkg.sv | 29 ++
 rtl/master_spi_bitclk.sv | 42 ++++
 rtl/master_spi.sv | 158 +++++++++++++++
 tb/tb_master_spi.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/master_spi_pkg.sv
// Shared definitions for the SPI master: AVR-slave register numbers and FSM encodings.
package master_spi_pkg;

  localparam logic [7:0] REG_KBD    = 8'h10;
  localparam logic [7:0] REG_KBDSTB = 8'h11;
  localparam logic [7:0] REG_MUSX   = 8'h20;
  localparam logic [7:0] REG_MUSY   = 8'h21;
  localparam logic [7:0] REG_MUSBTN = 8'h22;
  localparam logic [7:0] REG_KJ     = 8'h23;
  localparam logic [7:0] REG_RST    = 8'h30;
  localparam logic [7:0] REG_WAIT   = 8'h40;
  localparam logic [7:0] REG_GLUADR = 8'h41;
  localparam logic [7:0] REG_COMADR = 8'h42;
  localparam logic [7:0] REG_CFG0   = 8'h50;
  localparam logic [7:0] REG_CFG1   = 8'h51;
  localparam logic [7:0] REG_SDDATA = 8'h60;
  localparam logic [7:0] REG_SDCTRL = 8'h61;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ADDR = 3'd2,
    S_CSLO = 3'd3,
    S_DATA = 3'd4,
    S_CSHI = 3'd5,
    S_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/master_spi_bitclk.sv
// Bit-cell timer: HALF cycles spick low then HALF cycles high, with setup,
// sample and end-of-bit strobes. HALF must be at least 4 for the slave's resync.
module master_spi_bitclk #(
  parameter int unsigned HALF = 8
) (
  input  logic fclk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_sck,
  output logic o_setup,
  output logic o_sample,
  output logic o_bit_end
);

  localparam int unsigned CNT_W = $clog2(2 * HALF);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sck;

  assign o_setup   = i_run && (r_cnt == '0);
  assign o_sample  = i_run && (r_cnt == CNT_W'(HALF - 1));
  assign o_bit_end = i_run && (r_cnt == CNT_W'(2 * HALF - 1));
  assign o_sck     = r_sck;

  // spick is a flop so it rises on the first high-phase cycle without decode glitches.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!i_run) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else begin
      r_cnt <= o_bit_end ? '0 : r_cnt + 1'b1;
      if (o_sample)
        r_sck <= 1'b1;
      else if (o_bit_end)
        r_sck <= 1'b0;
    end
  end

endmodule

// File: rtl/master_spi.sv
// SPI master for the AVR-slave register protocol (address with CS_n high, payload with CS_n low).
// Optional address-phase status capture is built when MASTER_SPI_STATUS_EN is defined.
module master_spi
  import master_spi_pkg::*;
#(
  parameter int unsigned HALF   = 8,
  parameter int unsigned CS_GAP = 8
) (
  input  logic       fclk,
  input  logic       rst_n,
  output logic       spics_n,
  output logic       spick,
  output logic       spido,
  input  logic       spidi,
  input  logic       cmd_start,
  input  logic [7:0] cmd_reg,
  input  logic [5:0] cmd_len,
  input  logic [7:0] wr_data,
  output logic       wr_next,
  output logic [7:0] rd_data,
  output logic       rd_stb,
  output logic [7:0] status_out,
  output logic       busy,
  output logic       done
);

  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);

  state_e           r_state, w_state_nxt;
  logic [GAP_W-1:0] r_gap;
  logic [2:0]       r_bit;
  logic [5:0]       r_byte;
  logic [7:0]       r_tx, r_rx, r_rd_data;
  logic             r_spido, r_spics_n, r_busy, r_done, r_rd_stb;
  logic             r_spidi_s1, r_spidi_s2;
  logic             w_run, w_setup, w_sample, w_bit_end, w_sck;
  logic             w_gap_end, w_last_bit;
  logic [7:0]       w_tx_src;

  assign w_run      = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_gap_end  = (r_gap == GAP_W'(CS_GAP - 1));
  assign w_last_bit = (r_bit == 3'd7);
  assign w_tx_src   = (r_state == S_DATA && r_bit == 3'd0) ? wr_data : r_tx;

  master_spi_bitclk #(.HALF(HALF)) u_bitclk (
    .fclk      (fclk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .o_sck     (w_sck),
    .o_setup   (w_setup),
    .o_sample  (w_sample),
    .o_bit_end (w_bit_end)
  );

  // NOTE: every variable written here gets a default first, so no path leaves it holding a value (no latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (cmd_start) w_state_nxt = S_PRE;
      S_PRE:  if (w_gap_end) w_state_nxt = S_ADDR;
      S_ADDR: if (w_bit_end && w_last_bit) w_state_nxt = S_CSLO;
      S_CSLO: if (w_gap_end) w_state_nxt = (r_byte == 6'd0) ? S_CSHI : S_DATA;
      S_DATA: if (w_bit_end && w_last_bit && r_byte == 6'd1) w_state_nxt = S_CSHI;
      S_CSHI: if (w_gap_end) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gap      <= '0;
      r_bit      <= 3'd0;
      r_byte     <= 6'd0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_rd_data  <= 8'h00;
      r_spido    <= 1'b0;
      r_spics_n  <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_spidi_s1 <= 1'b0;
      r_spidi_s2 <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_spics_n  <= !(w_state_nxt inside {S_CSLO, S_DATA});
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_spidi_s1 <= spidi;
      r_spidi_s2 <= r_spidi_s1;

      if (w_state_nxt != r_state)
        r_gap <= '0;
      else if (r_state inside {S_PRE, S_CSLO, S_CSHI})
        r_gap <= r_gap + 1'b1;

      if (r_state == S_IDLE && cmd_start) begin
        r_tx   <= cmd_reg;
        r_byte <= cmd_len;
        r_bit  <= 3'd0;
      end

      // Launch the next bit at the start of the low phase; payload bytes load straight from wr_data.
      if (w_setup) begin
        r_spido <= w_tx_src[0];
        r_tx    <= {1'b0, w_tx_src[7:1]};
      end else if (r_state == S_DONE) begin
        r_spido <= 1'b0;
      end

      if (w_sample && r_state == S_DATA)
        r_rx <= {r_spidi_s2, r_rx[7:1]};

      r_rd_stb <= w_sample && (r_state == S_DATA) && w_last_bit;
      if (w_sample && r_state == S_DATA && w_last_bit)
        r_rd_data <= {r_spidi_s2, r_rx[7:1]};

      if (w_bit_end) begin
        r_bit <= r_bit + 1'b1;
        if (r_state == S_DATA && w_last_bit)
          r_byte <= r_byte - 1'b1;
      end
    end
  end

`ifdef MASTER_SPI_STATUS_EN
  logic [7:0] r_stat_sh, r_status;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_sh <= 8'h00;
      r_status  <= 8'h00;
    end else begin
      if (w_sample && r_state == S_ADDR)
        r_stat_sh <= {r_spidi_s2, r_stat_sh[7:1]};
      if (w_bit_end && w_last_bit && r_state == S_ADDR)
        r_status <= r_stat_sh;
    end
  end

  assign status_out = r_status;
`else
  assign status_out = 8'h00;
`endif

  assign spics_n = r_spics_n;
  assign spick   = w_sck;
  assign spido   = r_spido;
  assign wr_next = (r_state == S_DATA) && w_setup && (r_bit == 3'd0);
  assign rd_data = r_rd_data;
  assign rd_stb  = r_rd_stb;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_master_spi.sv
// Directed bench for master_spi with a behavioural AVR-style slave on the SPI pins.
module tb_master_spi;
  import master_spi_pkg::*;

  localparam int HALF      = 8;
  localparam int CS_GAP    = 8;
  localparam logic [7:0] STATUS_IN = 8'h81;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spics_n, spick, spido, spidi;
  logic       cmd_start = 1'b0;
  logic [7:0] cmd_reg = 8'h00;
  logic [5:0] cmd_len = 6'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_next, rd_stb, busy, done;
  logic [7:0] rd_data, status_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tx_q[$];

  always #5 fclk = ~fclk;

  master_spi #(.HALF(HALF), .CS_GAP(CS_GAP)) dut (
    .fclk(fclk), .rst_n(rst_n), .spics_n(spics_n), .spick(spick), .spido(spido),
    .spidi(spidi), .cmd_start(cmd_start), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_next(wr_next), .rd_data(rd_data), .rd_stb(rd_stb),
    .status_out(status_out), .busy(busy), .done(done)
  );

  // Slave model: shifts on spick rise, reloads on CS_n edges, commits on a whole-byte CS_n rise.
  logic [7:0]  sd_dataout = 8'h3C;
  logic [7:0]  s_rx = 8'h00, s_tx = STATUS_IN, s_addr = 8'h00, s_last = 8'h00, cfg0 = 8'h00;
  logic [39:0] kbd_acc = '0, kbd_out = '0;
  logic        s_cs_q = 1'b1;
  int          s_bits = 0, s_data_clks = 0, genrst_cnt = 0, kbd_stb_cnt = 0;

  assign spidi = s_tx[0];

  always @(posedge spick or spics_n) begin
    if (spics_n === 1'b0 && s_cs_q) begin
      s_cs_q = 1'b0;
      s_bits = 0;
      s_data_clks = 0;
      kbd_acc = '0;
      s_tx = (s_addr == REG_SDDATA) ? sd_dataout : 8'h00;
    end else if (spics_n === 1'b1 && !s_cs_q) begin
      s_cs_q = 1'b1;
      if (s_bits % 8 == 0) begin
        case (s_addr)
          REG_CFG0: cfg0 = s_last;
          REG_RST:  genrst_cnt++;
          REG_KBD:  begin kbd_out = kbd_acc; kbd_stb_cnt++; end
          default: ;
        endcase
      end
      s_bits = 0;
      s_tx = STATUS_IN;
    end else if (spick === 1'b1) begin
      s_rx = {spido, s_rx[7:1]};
      s_tx = s_tx >> 1;
      s_bits++;
      if (spics_n) begin
        if (s_bits == 8) s_addr = s_rx;
      end else begin
        s_data_clks++;
        if (s_bits % 8 == 0) begin
          s_last = s_rx;
          kbd_acc = {s_rx, kbd_acc[39:8]};
        end
      end
    end
  end

  function automatic int xfer_len(input int len);
    return (8 + 8 * len) * 2 * HALF + 3 * CS_GAP + 1;
  endfunction

  // Runs one command; cycles counts from cmd_start to the done cycle, or to the abort point.
  task automatic run_xfer(input logic [7:0] reg_n, input logic [5:0] len, input int inject_at,
                          input int abort_at, output int cycles, output int nwr, output int nrd,
                          output bit aborted);
    int  n;
    int  idx;
    bit  take;
    cycles = 0; nwr = 0; nrd = 0; aborted = 0; idx = 0; take = 0;
    wr_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    @(posedge fclk); #1;
    cmd_reg = reg_n; cmd_len = len; cmd_start = 1'b1;
    @(posedge fclk); #1;
    cmd_start = 1'b0; cmd_reg = 8'hFF; cmd_len = 6'h3F;
    n = 1;
    while (n < 3000) begin
      if (take) begin
        idx++;
        wr_data = (idx < tx_q.size()) ? tx_q[idx] : 8'h00;
        take = 0;
      end
      cmd_start = (inject_at == n);
      if (abort_at == n) begin
        rst_n = 1'b0;
        #1;
        aborted = 1;
        cycles = n;
        return;
      end
      if (wr_next) begin nwr++; take = 1; end
      if (rd_stb) nrd++;
      if (done) begin cycles = n; break; end
      @(posedge fclk); #1;
      n++;
    end
    cmd_start = 1'b0;
    n_checks++;
    if (cycles == 0) begin
      n_fail++;
      $display("FAIL xfer_timeout: reg %h got no done within %0d cycles", reg_n, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge fclk);
    #1;
    n_checks++; if (spics_n !== 1'b1) begin n_fail++; $display("FAIL reset_spics_n: got %b expected 1", spics_n); end
    n_checks++; if (spick !== 1'b0) begin n_fail++; $display("FAIL reset_spick: got %b expected 0", spick); end
    n_checks++; if (spido !== 1'b0) begin n_fail++; $display("FAIL reset_spido: got %b expected 0", spido); end
    n_checks++; if ({busy, done, wr_next, rd_stb} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, wr_next, rd_stb}); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    n_checks++; if (status_out !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", status_out); end
    @(negedge fclk) rst_n = 1'b1;
    repeat (4) @(posedge fclk);
    #1;
    n_checks++; if (busy !== 1'b0 || spics_n !== 1'b1) begin n_fail++; $display("FAIL idle_after_reset: busy %b spics_n %b expected 0 1", busy, spics_n); end
  endtask

  task automatic test_write_cfg0();
    int cyc, nwr, nrd; bit ab;
    tx_q = {8'hA5};
    run_xfer(REG_CFG0, 6'd1, 0, 0, cyc, nwr, nrd, ab);
    n_checks++; if (cyc != xfer_len(1)) begin n_fail++; $display("FAIL cfg0_length: got %0d expected %0d", cyc, xfer_len(1)); end
    n_checks++; if (s_addr !== 8'h50) begin n_fail++; $display("FAIL cfg0_addr_bits: got %h expected 50", s_addr); end
    n_checks++; if (cfg0 !== 8'hA5) begin n_fail++; $display("FAIL cfg0_commit: got %h expected a5", cfg0); end
    n_checks++; if (nwr != 1) begin n_fail++; $display("FAIL cfg0_wr_next: got %0d expected 1", nwr); end
    @(posedge fclk); #1;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg0_done_pulse: done %b busy %b expected 0 0", done, busy); end
  endtask

  task automatic test_addr_only();
    int cyc, nwr, nrd; bit ab;
    int g0;
    g0 = genrst_cnt;
    tx_q = {};
    run_xfer(REG_RST, 6'd0, 0, 0, cyc, nwr, nrd, ab);
    n_checks++; if (cyc != 16 * HALF + 3 * CS_GAP + 1) begin n_fail++; $display("FAIL rst_length: got %0d expected %0d", cyc, 16 * HALF + 3 * CS_GAP + 1); end
    n_checks++; if (genrst_cnt != g0 + 1) begin n_fail++; $display("FAIL rst_genrst: got %0d expected %0d", genrst_cnt, g0 + 1); end
    n_checks++; if (s_data_clks != 0 || nwr != 0) begin n_fail++; $display("FAIL rst_no_payload: clocks %0d wr_next %0d expected 0 0", s_data_clks, nwr); end
  endtask

  task automatic test_read_sd();
    int cyc, nwr, nrd; bit ab;
    tx_q = {8'h00};
    sd_dataout = 8'h3C;
    run_xfer(REG_SDDATA, 6'd1, 0, 0, cyc, nwr, nrd, ab);
    n_checks++; if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL sd_read_3c: got %h expected 3c", rd_data); end
    n_checks++; if (nrd != 1) begin n_fail++; $display("FAIL sd_rd_stb: got %0d expected 1", nrd); end
    sd_dataout = 8'hD2;
    run_xfer(REG_SDDATA, 6'd1, 0, 0, cyc, nwr, nrd, ab);
    n_checks++; if (rd_data !== 8'hD2) begin n_fail++; $display("FAIL sd_read_d2: got %h expected d2", rd_data); end
  endtask

  task automatic test_status();
    int cyc, nwr, nrd; bit ab;
    logic [7:0] exp_status;
`ifdef MASTER_SPI_STATUS_EN
    exp_status = STATUS_IN;
`else
    exp_status = 8'h00;
`endif
    tx_q = {};
    run_xfer(REG_WAIT, 6'd0, 0, 0, cyc, nwr, nrd, ab);
    n_checks++; if (status_out !== exp_status) begin n_fail++; $display("FAIL status_out: got %h expected %h", status_out, exp_status); end
  endtask

  task automatic test_burst_ignore_start();
    int cyc, nwr, nrd; bit ab;
    int k0;
    k0 = kbd_stb_cnt;
    tx_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_xfer(REG_KBD, 6'd5, 200, 0, cyc, nwr, nrd, ab);
    n_checks++; if (cyc != xfer_len(5)) begin n_fail++; $display("FAIL burst_length: got %0d expected %0d", cyc, xfer_len(5)); end
    n_checks++; if (nwr != 5) begin n_fail++; $display("FAIL burst_wr_next: got %0d expected 5", nwr); end
    n_checks++; if (kbd_out !== 40'h0504030201) begin n_fail++; $display("FAIL burst_kbd: got %h expected 0504030201", kbd_out); end
    n_checks++; if (kbd_stb_cnt != k0 + 1) begin n_fail++; $display("FAIL burst_kbd_stb: got %0d expected %0d", kbd_stb_cnt, k0 + 1); end
    repeat (30) @(posedge fclk);
    #1;
    n_checks++; if (busy !== 1'b0 || spics_n !== 1'b1) begin n_fail++; $display("FAIL burst_no_restart: busy %b spics_n %b expected 0 1", busy, spics_n); end
  endtask

  task automatic test_abort();
    int cyc, nwr, nrd; bit ab;
    int k0;
    k0 = kbd_stb_cnt;
    tx_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_xfer(REG_KBD, 6'd5, 0, 331, cyc, nwr, nrd, ab);
    n_checks++; if (!ab || nwr != 2) begin n_fail++; $display("FAIL abort_point: aborted %0d wr_next %0d expected 1 2", ab, nwr); end
    n_checks++; if (spics_n !== 1'b1 || spick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: spics_n %b spick %b busy %b expected 1 0 0", spics_n, spick, busy); end
    @(negedge fclk) rst_n = 1'b1;
    repeat (20) @(posedge fclk);
    #1;
    n_checks++; if (kbd_stb_cnt != k0) begin n_fail++; $display("FAIL abort_no_commit: got %0d expected %0d", kbd_stb_cnt, k0); end
    n_checks++; if (busy !== 1'b0 || spics_n !== 1'b1) begin n_fail++; $display("FAIL abort_idle: busy %b spics_n %b expected 0 1", busy, spics_n); end
  endtask

  initial begin
    test_reset();
    test_write_cfg0();
    test_addr_only();
    test_read_sd();
    test_status();
    test_burst_ignore_start();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
